// File: rtl/riscv_core_div_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : riscv_core_div_pkg                                                 |
// | Shared op encodings, FSM states and widths for the divider issue logic.      |
// | Rev 1.0 : initial release                                                    |
// +-----------------------------------------------------------------------------+
package riscv_core_div_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int WORD_MSB     = 31;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4
  } div_issue_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_core_div_fastpath.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : riscv_core_div_fastpath                                            |
// | Detects divide-by-zero and signed overflow and produces their result.        |
// | Rev 1.0 : initial release                                                    |
// +-----------------------------------------------------------------------------+
module riscv_core_div_fastpath
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      i_op,
  input  logic            i_isword,
  input  logic [XLEN-1:0] i_srcA,
  input  logic [XLEN-1:0] i_srcB,
  output logic            o_hit,
  output logic [XLEN-1:0] o_data
);

  logic            w_b_zero;
  logic            w_b_m1;
  logic            w_a_min;
  logic [XLEN-1:0] w_a_sext;
  logic [XLEN-1:0] w_a_sel;

  always_comb begin
    w_a_sext = {{(XLEN-WORD_MSB-1){i_srcA[WORD_MSB]}}, i_srcA[WORD_MSB:0]};
    if (i_isword) begin
      w_b_zero = (i_srcB[WORD_MSB:0] == 32'h0);
      w_b_m1   = &i_srcB[WORD_MSB:0];
      w_a_min  = (i_srcA[WORD_MSB:0] == 32'h8000_0000);
      w_a_sel  = w_a_sext;
    end else begin
      w_b_zero = (i_srcB == '0);
      w_b_m1   = &i_srcB;
      w_a_min  = (i_srcA == {1'b1, {(XLEN-1){1'b0}}});
      w_a_sel  = i_srcA;
    end

    // op[0]=0 is signed, op[1]=1 is remainder
    o_hit  = w_b_zero | (~i_op[0] & w_a_min & w_b_m1);
    o_data = '0;
    if (w_b_zero) begin
      o_data = i_op[1] ? w_a_sel : '1;
    end else if (!i_op[1]) begin
      o_data = w_a_sel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_core_div_issue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : riscv_core_div_issue                                               |
// | EX-stage divide initiator: stalls, drives the divider, emits writeback.      |
// | Option  : DIV_ISSUE_FASTPATH_EN bypasses the divider for /0 and overflow.    |
// | Rev 1.0 : initial release                                                    |
// +-----------------------------------------------------------------------------+
module riscv_core_div_issue
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = 5
) (
  input  logic              i_divissue_clk,
  input  logic              i_divissue_rstn,
  input  logic              i_divissue_valid,
  input  logic [1:0]        i_divissue_op,
  input  logic              i_divissue_isword,
  input  logic [XLEN-1:0]   i_divissue_srcA,
  input  logic [XLEN-1:0]   i_divissue_srcB,
  input  logic [REG_AW-1:0] i_divissue_rd,
  input  logic              i_divissue_flush,
  output logic              o_divissue_div_en,
  output logic [XLEN-1:0]   o_divissue_div_srcA,
  output logic [XLEN-1:0]   o_divissue_div_srcB,
  output logic [1:0]        o_divissue_div_ctrl,
  output logic              o_divissue_div_isword,
  input  logic              i_divissue_div_busy,
  input  logic              i_divissue_div_done,
  input  logic [XLEN-1:0]   i_divissue_div_result,
  output logic              o_divissue_stall,
  output logic              o_divissue_wb_valid,
  output logic [REG_AW-1:0] o_divissue_wb_rd,
  output logic [XLEN-1:0]   o_divissue_wb_data
);

  div_issue_state_e  r_state;
  div_issue_state_e  w_next;
  logic [XLEN-1:0]   r_srcA;
  logic [XLEN-1:0]   r_srcB;
  logic [XLEN-1:0]   r_result;
  logic [1:0]        r_op;
  logic              r_isword;
  logic [REG_AW-1:0] r_rd;
  logic              w_accept;
  logic              w_capture;
  logic              w_fast_hit;
  logic [XLEN-1:0]   w_fast_data;

`ifdef DIV_ISSUE_FASTPATH_EN
  riscv_core_div_fastpath #(.XLEN(XLEN)) u_fastpath (
    .i_op     (i_divissue_op),
    .i_isword (i_divissue_isword),
    .i_srcA   (i_divissue_srcA),
    .i_srcB   (i_divissue_srcB),
    .o_hit    (w_fast_hit),
    .o_data   (w_fast_data)
  );
`else
  assign w_fast_hit  = 1'b0;
  assign w_fast_data = '0;
`endif

  always_ff @(posedge i_divissue_clk or negedge i_divissue_rstn) begin
    if (!i_divissue_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next              = r_state;
    w_accept            = 1'b0;
    w_capture           = 1'b0;
    o_divissue_div_en   = 1'b0;
    o_divissue_wb_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_divissue_valid && !i_divissue_flush) begin
          w_accept = 1'b1;
          w_next   = w_fast_hit ? S_WB : S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        o_divissue_div_en = 1'b1;
        // A flush landing on the done cycle has nothing left to drain
        if (i_divissue_flush) begin
          w_next = i_divissue_div_done ? S_IDLE : S_DRAIN;
        end else if (i_divissue_div_done) begin
          w_capture = 1'b1;
          w_next    = S_WB;
        end else if (i_divissue_div_busy) begin
          w_next = S_WAIT;
        end
      end
      S_DRAIN: begin
        o_divissue_div_en = 1'b1;
        if (i_divissue_div_done) begin
          w_next = S_IDLE;
        end
      end
      S_WB: begin
        o_divissue_wb_valid = ~i_divissue_flush;
        w_next              = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_divissue_clk or negedge i_divissue_rstn) begin
    if (!i_divissue_rstn) begin
      r_srcA   <= '0;
      r_srcB   <= '0;
      r_op     <= '0;
      r_isword <= 1'b0;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_srcA   <= i_divissue_srcA;
        r_srcB   <= i_divissue_srcB;
        r_op     <= i_divissue_op;
        r_isword <= i_divissue_isword;
        r_rd     <= i_divissue_rd;
        if (w_fast_hit) begin
          r_result <= w_fast_data;
        end
      end
      if (w_capture) begin
        r_result <= i_divissue_div_result;
      end
    end
  end

  // Gated by reset so the stall output is also zero while rstn is low
  assign o_divissue_stall = i_divissue_rstn &
                            ((i_divissue_valid & (r_state != S_WB)) | (r_state == S_DRAIN));

  assign o_divissue_div_srcA   = r_srcA;
  assign o_divissue_div_srcB   = r_srcB;
  assign o_divissue_div_ctrl   = r_op;
  assign o_divissue_div_isword = r_isword;
  assign o_divissue_wb_rd      = r_rd;
  assign o_divissue_wb_data    = r_result;

endmodule
`default_nettype wire
